game_controller: RTL

//  Game-state and scoring stage downstream of the bird/pipe painters. Watches the
//  per-pixel bird/pipe flags each frame for collisions and runs the

---
 rtl/game_controller_pkg.sv | 49 ++++
 rtl/game_controller_seg7_decode.sv | 29 ++
 rtl/game_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/game_controller_pkg.sv
// Shared definitions for the game controller: FSM state encoding, active-low
// 7-segment patterns and small BCD helper functions.
package game_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2,
    ST_BAD  = 2'd3   // unreachable encoding, recovers to IDLE
  } state_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99) begin
      r = s;
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD-aware "a > b": tens digit decides unless equal, then ones digit.
  function automatic logic bcd_gt(input logic [7:0] a, input logic [7:0] b);
    logic r;
    if (a[7:4] != b[7:4]) begin
      r = (a[7:4] > b[7:4]);
    end else begin
      r = (a[3:0] > b[3:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/game_controller_seg7_decode.sv
// seg7_decode: one BCD digit to active-low 7-segment pattern (combinational).
//  bcd  in  4  digit 0..9 (other codes blank the display)
//  seg  out 7  {g,f,e,d,c,b,a}, 0 = segment on
module seg7_decode
  import game_controller_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/game_controller.sv
// game_controller: IDLE/PLAY/DEAD sequencing, per-frame collision detection,
// BCD score / high score and game-over LED blink.
//  sys_clock, rst_n          clock, async active-low reset
//  frame_tick                one-cycle end-of-frame pulse
//  video_on,bird_pix,pipe_pix per-pixel flags; all three high = collision
//  tap, game_reset           debounced one-cycle button pulses
//  run_en, dead              state decode (PLAY / DEAD)
//  score_bcd, high_bcd       {tens,ones} BCD
//  hex0/hex1, hex4/hex5      score / high digits, active-low segments
//  ledr                      all-on / all-off blink while DEAD
module game_controller
  import game_controller_pkg::*;
#(
  parameter int SCORE_DIV    = 70,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       sys_clock,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       video_on,
  input  logic       bird_pix,
  input  logic       pipe_pix,
  input  logic       tap,
  input  logic       game_reset,
  output logic       run_en,
  output logic       dead,
  output logic [7:0] score_bcd,
  output logic [7:0] high_bcd,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [9:0] ledr
);

  localparam int FW = $clog2(SCORE_DIV);
  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCORE_DIV - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    high_q, high_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          coll_q, coll_d;
  logic [9:0]    ledr_q, ledr_d;
  logic          overlap;

  assign overlap = video_on & bird_pix & pipe_pix;

  // Next-state logic; game_reset outranks frame_tick, which outranks tap.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    high_d      = high_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    coll_d      = coll_q;
    ledr_d      = ledr_q;
    if (game_reset) begin
      state_d = ST_IDLE;
      score_d = 8'h00;
      ledr_d  = 10'h000;
      coll_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tap) begin
            state_d     = ST_PLAY;
            score_d     = 8'h00;
            frame_cnt_d = '0;
            coll_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            // The flag covers the whole frame; this cycle's overlap counts too.
            coll_d = 1'b0;
            if (coll_q | overlap) begin
              state_d     = ST_DEAD;
              blink_cnt_d = '0;
              ledr_d      = 10'h3FF;
              if (bcd_gt(score_q, high_q)) begin
                high_d = score_q;
              end else begin
                high_d = high_q;
              end
            end else if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_d = '0;
              score_d     = bcd_inc_sat(score_q);
            end else begin
              frame_cnt_d = frame_cnt_q + FRAME_ONE;
            end
          end else if (overlap) begin
            coll_d = 1'b1;
          end else begin
            coll_d = coll_q;
          end
        end
        ST_DEAD: begin
          if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              ledr_d      = ~ledr_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_ONE;
            end
          end else begin
            blink_cnt_d = blink_cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          score_d = 8'h00;
          ledr_d  = 10'h000;
          coll_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      score_q     <= 8'h00;
      high_q      <= 8'h00;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      coll_q      <= 1'b0;
      ledr_q      <= 10'h000;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      coll_q      <= coll_d;
      ledr_q      <= ledr_d;
    end
  end

  assign run_en    = (state_q == ST_PLAY);
  assign dead      = (state_q == ST_DEAD);
  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign ledr      = ledr_q;

  seg7_decode u_hex0 (.bcd(score_q[3:0]), .seg(hex0));
  seg7_decode u_hex1 (.bcd(score_q[7:4]), .seg(hex1));
  seg7_decode u_hex4 (.bcd(high_q[3:0]),  .seg(hex4));
  seg7_decode u_hex5 (.bcd(high_q[7:4]),  .seg(hex5));

endmodule
